// File: rtl/regset_arbiter_if.sv
// Requester and regset-facing signal bundle for regset_arbiter.
// The slave modport is the arbiter's view; master is the requester/regset side.
interface regset_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic [1:0]         i_req;
  logic [1:0]         i_we;
  logic [1:0]         i_sel;
  logic [2*WIDTH-1:0] i_wdata;
  logic [1:0]         o_ack;
  logic [WIDTH-1:0]   o_rdata;
  logic               o_busy;
  logic [WIDTH-1:0]   o_d;
  logic               o_write0;
  logic               o_write1;
  logic               o_busSel;
  logic               o_busEn;
  logic               o_regReset;
  logic [WIDTH-1:0]   i_bus;

  modport slave (
    input  i_req, i_we, i_sel, i_wdata, i_bus,
    output o_ack, o_rdata, o_busy, o_d, o_write0, o_write1,
           o_busSel, o_busEn, o_regReset
  );

  modport master (
    output i_req, i_we, i_sel, i_wdata, i_bus,
    input  o_ack, o_rdata, o_busy, o_d, o_write0, o_write1,
           o_busSel, o_busEn, o_regReset
  );
endinterface

// File: rtl/regset_arbiter.sv
// Round-robin sequencer giving two requesters one-at-a-time access to the
// regset write strobes and its bus transmitter; all outputs registered.
module regset_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned READ_WAIT = 1
) (
  input logic             i_clk,
  input logic             i_nReset,
  regset_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_last;
  logic               r_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_ack;
  logic [WIDTH-1:0]   r_rdata;
  logic [WIDTH-1:0]   r_d;
  logic               r_busy;
  logic               r_write0;
  logic               r_write1;
  logic               r_busSel;
  logic               r_busEn;
  logic               r_regReset;

  logic               w_any;
  logic               w_both;
  logic               w_grant;
  logic               w_we;
  logic               w_sel;
  logic [WIDTH-1:0]   w_wdata;
  logic [1:0]         w_ack_new;
  logic [1:0]         w_ack_held;

  // A lone requester always wins; on contention the pointer alternates.
  assign w_any      = |bus.i_req;
  assign w_both     = &bus.i_req;
  assign w_grant    = w_both ? ~r_last : bus.i_req[1];
  assign w_we       = bus.i_we[w_grant];
  assign w_sel      = bus.i_sel[w_grant];
  assign w_wdata    = w_grant ? bus.i_wdata[2*WIDTH-1:WIDTH] : bus.i_wdata[WIDTH-1:0];
  assign w_ack_new  = w_grant ? 2'b10 : 2'b01;
  assign w_ack_held = r_grant ? 2'b10 : 2'b01;

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_state    <= S_INIT;
      r_last     <= 1'b1;
      r_grant    <= 1'b0;
      r_cnt      <= '0;
      r_ack      <= 2'b00;
      r_rdata    <= '0;
      r_d        <= '0;
      r_busy     <= 1'b0;
      r_write0   <= 1'b0;
      r_write1   <= 1'b0;
      r_busSel   <= 1'b0;
      r_busEn    <= 1'b0;
      r_regReset <= 1'b1;
    end else begin
      case (r_state)
        S_INIT: begin
          r_regReset <= 1'b0;
          r_state    <= S_IDLE;
        end

        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_grant;
            r_busy  <= 1'b1;
            if (w_both) begin
              r_last <= w_grant;
            end
            if (w_we) begin
              r_d      <= w_wdata;
              r_write0 <= ~w_sel;
              r_write1 <= w_sel;
              r_ack    <= w_ack_new;
              r_state  <= S_WRITE;
            end else begin
              r_busEn  <= 1'b1;
              r_busSel <= w_sel;
              r_cnt    <= CNT_W'(READ_WAIT - 1);
              r_state  <= S_READ;
            end
          end
        end

        S_WRITE: begin
          r_write0 <= 1'b0;
          r_write1 <= 1'b0;
          r_ack    <= 2'b00;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end

        // Bus is sampled at the edge that closes the last enabled cycle.
        S_READ: begin
          if (r_cnt == '0) begin
            r_rdata <= bus.i_bus;
            r_busEn <= 1'b0;
            r_ack   <= w_ack_held;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_DONE: begin
          r_ack   <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_write0 <= 1'b0;
          r_write1 <= 1'b0;
          r_busEn  <= 1'b0;
          r_ack    <= 2'b00;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ack      = r_ack;
  assign bus.o_rdata    = r_rdata;
  assign bus.o_busy     = r_busy;
  assign bus.o_d        = r_d;
  assign bus.o_write0   = r_write0;
  assign bus.o_write1   = r_write1;
  assign bus.o_busSel   = r_busSel;
  assign bus.o_busEn    = r_busEn;
  assign bus.o_regReset = r_regReset;

endmodule
